// File: rtl/instr_pkg.sv
// Shared instruction-format definitions: format codes, field widths and bit
// positions (same layout as the decoder), and the loader FSM state encoding.
package instr_pkg;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_ILL = 2'd3;

  localparam int OPC_W = 6;
  localparam int REG_W = 5;
  localparam int SHF_W = 5;
  localparam int FUN_W = 6;
  localparam int IMM_W = 16;
  localparam int TGT_W = 26;

  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int SHF_LSB = 6;
  localparam int FUN_LSB = 0;
  localparam int IMM_LSB = 0;
  localparam int TGT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FULL   = 2'd3
  } state_t;

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packer: selects the field layout for the given format and
// flags the reserved format code as illegal.
module instr_word_pack
  import instr_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shift,
  input  logic [5:0]  funct,
  input  logic [15:0] immediate,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    word[OPC_LSB +: OPC_W] = opcode;
    case (fmt)
      FMT_R: begin
        word[RS_LSB  +: REG_W] = rs;
        word[RT_LSB  +: REG_W] = rt;
        word[RD_LSB  +: REG_W] = rd;
        word[SHF_LSB +: SHF_W] = shift;
        word[FUN_LSB +: FUN_W] = funct;
      end
      FMT_I: begin
        word[RS_LSB  +: REG_W] = rs;
        word[RT_LSB  +: REG_W] = rt;
        word[IMM_LSB +: IMM_W] = immediate;
      end
      FMT_J: word[TGT_LSB +: TGT_W] = target;
      default: begin
        word    = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder_loader.sv
// Accepts instruction field sets, packs them and streams the words into
// consecutive instruction-memory addresses, one word every two cycles.
module instruction_encoder_loader
  import instr_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shift,
  input  logic [5:0]        funct,
  input  logic [15:0]       immediate,
  input  logic [25:0]       target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              full,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word;
  logic              illegal;
  logic              take, load, at_top;

  instr_word_pack u_pack (
    .fmt       (fmt),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shift     (shift),
    .funct     (funct),
    .immediate (immediate),
    .target    (target),
    .word      (word),
    .illegal   (illegal)
  );

  // stop always beats a transfer or a (re)start in the same cycle
  assign take   = (state == ST_ACCEPT) && in_valid && !stop;
  assign load   = ((state == ST_IDLE) || (state == ST_FULL)) && start && !stop;
  assign at_top = &addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (load) state_nxt = ST_ACCEPT;
      ST_ACCEPT: begin
        if (stop)                  state_nxt = ST_IDLE;
        else if (take && !illegal) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (stop)        state_nxt = ST_IDLE;
        else if (at_top) state_nxt = ST_FULL;
        else             state_nxt = ST_ACCEPT;
      end
      ST_FULL: begin
        if (stop)      state_nxt = ST_IDLE;
        else if (load) state_nxt = ST_ACCEPT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Decoded from state so reset kills the write strobe without waiting for a clock
  always_comb begin
    in_ready = (state == ST_ACCEPT);
    mem_we   = (state == ST_WRITE);
    busy     = (state != ST_IDLE);
    full     = (state == ST_FULL);
  end

  // addr is the next free slot; mem_addr/mem_wdata only change on acceptance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      err <= take && illegal;
      if (load) begin
        addr  <= base_addr;
        count <= '0;
      end
      if (take && !illegal) begin
        mem_addr  <= addr;
        mem_wdata <= word;
      end
      if (state == ST_WRITE) begin
        count <= count + CNT_W'(1);
        if (!at_top) addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: doc/instruction_encoder_loader.md
INSTRUCTION_ENCODER_LOADER -- requirements
Module: instruction_encoder_loader

Interface
REQ-001 Parameter ADDR_W, default 8: word-address width of the instruction memory write port.
REQ-002 clock  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  begin a load session at base_addr.
REQ-005 stop  in  1  end the session; return to IDLE.
REQ-006 base_addr  in  ADDR_W  first word address of the session.
REQ-007 in_valid  in  1  field set valid.
REQ-008 in_ready  out  1  encoder accepts a field set this cycle.
REQ-009 fmt  in  2  format: 0=R, 1=I, 2=J, 3=illegal.
REQ-010 opcode  in  6  opcode field.
REQ-011 rs, rt, rd, shift  in  5 each  register and shift fields.
REQ-012 funct  in  6  function field.
REQ-013 immediate  in  16  I-type immediate.
REQ-014 target  in  26  J-type target.
REQ-015 mem_we  out  1  one-cycle instruction-memory write strobe.
REQ-016 mem_addr  out  ADDR_W  write word address.
REQ-017 mem_wdata  out  32  encoded instruction word.
REQ-018 count  out  ADDR_W+1  words written this session.
REQ-019 busy  out  1  high when state is not IDLE.
REQ-020 full  out  1  high in state FULL.
REQ-021 err  out  1  one-cycle pulse on an accepted illegal fmt.

Function
REQ-022 Packing: R = {opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shift[10:6], funct[5:0]}; I = {opcode, rs, rt, immediate[15:0]}; J = {opcode, target[25:0]}; unused input fields ignored.
REQ-023 FSM states: IDLE, ACCEPT, WRITE, FULL.
REQ-024 IDLE: in_ready=0; start -> load addr=base_addr, count=0, go to ACCEPT.
REQ-025 ACCEPT: in_ready=1; in_valid with fmt 0..2 -> register packed word, go to WRITE.
REQ-026 ACCEPT: in_valid with fmt=3 -> consume the transfer, pulse err next cycle, no write, stay in ACCEPT.
REQ-027 WRITE: mem_we=1 for exactly one cycle with the registered mem_addr and mem_wdata; in_ready=0; then addr+1 and count+1.
REQ-028 WRITE when addr is all ones: go to FULL with no address wrap; otherwise return to ACCEPT.
REQ-029 Latency: a transfer accepted at cycle N produces mem_we at cycle N+1; sustained throughput is one word every 2 cycles.
REQ-030 FULL: in_ready=0 and full=1; start -> reload base_addr, clear count, go to ACCEPT; stop -> IDLE.
REQ-031 stop in ACCEPT -> IDLE; if in_valid is high in the same cycle, stop wins and no transfer occurs.
REQ-032 stop in WRITE: the write completes, then the FSM goes to IDLE.
REQ-033 start is ignored in ACCEPT and WRITE.
REQ-034 start and stop together: stop wins.
REQ-035 mem_wdata and mem_addr hold their values outside WRITE; only mem_we qualifies them.

Reset
REQ-036 Asynchronous reset forces: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, count=0, err=0, in_ready=0, busy=0, full=0.
REQ-037 Reset asserted during WRITE aborts the write immediately, with mem_we low in the same cycle reset is asserted.

Structure
REQ-038 Shared package instr_pkg holds the format codes, the field widths, the field bit positions (the same positions the decoder uses), and the FSM state encoding.
REQ-039 Packing is a combinational sub-module, instr_word_pack (fmt and fields in, 32-bit word and illegal flag out), instantiated once.

Verification
REQ-040 R-type: start with base 0x10; fmt=0, opcode=0, rs=1, rt=2, rd=3, shift=0, funct=0x20 -> mem_we at addr 0x10, data 0x00221820, count=1.
REQ-041 I-type then J-type back-to-back: opcode=0x08, rs=1, rt=2, imm=0x0005 -> 0x20220005 at addr 0x11; opcode=2, target=0x10 -> 0x08000010 at addr 0x12; in_ready low in each WRITE cycle.
REQ-042 Illegal fmt=3 -> err pulses once, no mem_we, address unchanged; the next legal word goes to the same address.
REQ-043 Boundary: base 0xFE with ADDR_W=8; three valid words -> writes at 0xFE and 0xFF, then full=1, in_ready=0, third word not accepted, count=2; start -> ACCEPT again at base.
REQ-044 Control: stop and in_valid in the same cycle -> no write, IDLE; stop during WRITE -> write completes, then IDLE.
REQ-045 Reset asserted in the WRITE cycle -> mem_we drops asynchronously and all outputs return to reset values.
